enc_acq_ctrl: RTL and testbench

Acquisition controller for a bank of P_NCH encoder counter channels. It arms the channels selected by a channel mask and sequences the acquisition window (start, run, stop or timeout, drain). It snapshots each channel's count on that channel's ready pulse and serialises the snapshots through a round-robin arbiter onto one valid/ack output stream for the DAQ readout path.

---
 rtl/enc_acq_pkg.sv | 31 +++
 rtl/enc_acq_ctrl_if.sv | 36 +++
 rtl/enc_rr_arb.sv | 32 +++
 rtl/enc_acq_ctrl.sv | 114 +++++++++++
 tb/tb_enc_acq_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/enc_acq_pkg.sv
// Shared types and helpers for the encoder acquisition controller:
// FSM state encoding, default widths and the round-robin pick function.
package enc_acq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int NCH_DEF   = 4;
  localparam int CW_DEF    = 64;
  localparam int IW_DEF    = 2;
  localparam int DROPW_DEF = 16;
  localparam int NCH_MAX   = 16;

  // First requesting channel at or after ptr, wrapping at n; returns ptr when idle.
  function automatic logic [3:0] rr_pick(input logic [NCH_MAX-1:0] req,
                                         input logic [3:0]         ptr,
                                         input logic [4:0]         n);
    logic [4:0] k;
    rr_pick = ptr;
    for (int i = NCH_MAX - 1; i >= 0; i--) begin
      k = {1'b0, ptr} + 5'(i);
      if (k >= n) k = k - n;
      if ((5'(i) < n) && req[k[3:0]]) rr_pick = k[3:0];
    end
  endfunction

endpackage

// File: rtl/enc_acq_ctrl_if.sv
// Control, channel-capture and readout-stream signals of the acquisition controller.
// The slave side is the controller; the master side is whoever drives it.
interface enc_acq_ctrl_if import enc_acq_pkg::*; #(
  parameter int P_NCH   = NCH_DEF,
  parameter int P_CW    = CW_DEF,
  parameter int P_IW    = IW_DEF,
  parameter int P_DROPW = DROPW_DEF
);
  logic                    I_START;
  logic                    I_STOP;
  logic [P_NCH-1:0]        I_CH_EN;
  logic [31:0]             I_TIMEOUT;
  logic [P_NCH-1:0]        O_ARM;
  logic [P_NCH*P_CW-1:0]   I_CNT;
  logic [P_NCH-1:0]        I_OVF;
  logic [P_NCH-1:0]        I_RDY;
  logic                    O_VALID;
  logic                    I_ACK;
  logic [P_CW-1:0]         O_DATA;
  logic [P_IW-1:0]         O_CH;
  logic                    O_OVF;
  logic                    O_BUSY;
  logic                    O_DONE;
  logic                    O_TIMEOUT;
  logic [P_DROPW-1:0]      O_DROP;

  modport slave (
    input  I_START, I_STOP, I_CH_EN, I_TIMEOUT, I_CNT, I_OVF, I_RDY, I_ACK,
    output O_ARM, O_VALID, O_DATA, O_CH, O_OVF, O_BUSY, O_DONE, O_TIMEOUT, O_DROP
  );

  modport master (
    output I_START, I_STOP, I_CH_EN, I_TIMEOUT, I_CNT, I_OVF, I_RDY, I_ACK,
    input  O_ARM, O_VALID, O_DATA, O_CH, O_OVF, O_BUSY, O_DONE, O_TIMEOUT, O_DROP
  );
endinterface

// File: rtl/enc_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant over req, priority pointer
// moves to the channel after the winner on adv; channel 0 first after reset.
module enc_rr_arb import enc_acq_pkg::*; #(
  parameter int P_NCH = NCH_DEF,
  parameter int P_IW  = IW_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [P_NCH-1:0] req,
  input  logic             adv,
  output logic [P_NCH-1:0] grant,
  output logic [P_IW-1:0]  idx
);

  logic [3:0] ptr;
  logic [3:0] pick;

  always_comb begin
    pick  = rr_pick(NCH_MAX'(req), ptr, 5'(P_NCH));
    idx   = P_IW'(pick);
    grant = (|req) ? (P_NCH'(1) << idx) : '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr <= 4'd0;
    end else if (adv) begin
      ptr <= (pick == 4'(P_NCH - 1)) ? 4'd0 : pick + 4'd1;
    end
  end

endmodule

// File: rtl/enc_acq_ctrl.sv
// Arms masked encoder channels, runs the acquisition window and serialises per-channel
// snapshots onto one valid/ack stream; a word appears >=1 cycle after capture and holds while not acked.
module enc_acq_ctrl import enc_acq_pkg::*; #(
  parameter int P_NCH   = NCH_DEF,
  parameter int P_CW    = CW_DEF,
  parameter int P_IW    = IW_DEF,
  parameter int P_DROPW = DROPW_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  enc_acq_ctrl_if.slave bus
);

  localparam int DSUMW = P_DROPW + 1;

  state_t             state, state_nxt;
  logic [P_NCH-1:0]   mask, pend, hovf;
  logic [P_NCH-1:0]   cap, gnt, gnt_used, ovw;
  logic [P_CW-1:0]    hold [P_NCH];
  logic [P_IW-1:0]    gidx;
  logic [31:0]        tcnt;
  logic               tmo_hit, load;
  logic [DSUMW-1:0]   drop_sum;
  logic [P_DROPW-1:0] drop_nxt;

  enc_rr_arb #(.P_NCH(P_NCH), .P_IW(P_IW)) u_arb (
    .CLK   (CLK),
    .RST   (RST),
    .req   (pend),
    .adv   (load),
    .grant (gnt),
    .idx   (gidx)
  );

  always_comb begin
    cap      = (state == RUN) ? (bus.I_RDY & mask) : '0;
    load     = (!bus.O_VALID || bus.I_ACK) && (|pend);
    gnt_used = load ? gnt : '0;
    // A capture landing on the channel being granted is a refill, not a drop.
    ovw      = cap & pend & ~gnt_used;
    tmo_hit  = (state == RUN) && (bus.I_TIMEOUT != 32'd0) &&
               (tcnt == bus.I_TIMEOUT - 32'd1);
    drop_sum = {1'b0, bus.O_DROP};
    for (int k = 0; k < P_NCH; k++) drop_sum = drop_sum + DSUMW'(ovw[k]);
    drop_nxt = drop_sum[P_DROPW] ? '1 : drop_sum[P_DROPW-1:0];
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.I_START) state_nxt = RUN;
      RUN:     if (bus.I_STOP || tmo_hit) state_nxt = DRAIN;
      DRAIN:   if ((pend == '0) && !bus.O_VALID) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.O_ARM  = (state == RUN) ? mask : '0;
    bus.O_BUSY = (state != IDLE);
    bus.O_DONE = (state == DONE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mask          <= '0;
      pend          <= '0;
      tcnt          <= '0;
      bus.O_VALID   <= 1'b0;
      bus.O_DATA    <= '0;
      bus.O_CH      <= '0;
      bus.O_OVF     <= 1'b0;
      bus.O_TIMEOUT <= 1'b0;
      bus.O_DROP    <= '0;
    end else begin
      pend <= (pend & ~gnt_used) | cap;
      if ((state == IDLE) && bus.I_START) begin
        mask          <= bus.I_CH_EN;
        tcnt          <= '0;
        bus.O_TIMEOUT <= 1'b0;
        bus.O_DROP    <= '0;
      end else begin
        if (state == RUN) tcnt <= (|cap) ? '0 : tcnt + 32'd1;
        if (tmo_hit && !bus.I_STOP) bus.O_TIMEOUT <= 1'b1;
        bus.O_DROP <= drop_nxt;
      end
      if (load) begin
        bus.O_VALID <= 1'b1;
        bus.O_DATA  <= hold[gidx];
        bus.O_CH    <= gidx;
        bus.O_OVF   <= hovf[gidx];
      end else if (bus.I_ACK) begin
        bus.O_VALID <= 1'b0;
      end
    end
  end

  // Snapshot storage is qualified by pend, so it needs no reset.
  always_ff @(posedge CLK) begin
    for (int k = 0; k < P_NCH; k++) begin
      if (cap[k]) begin
        hold[k] <= bus.I_CNT[k*P_CW +: P_CW];
        hovf[k] <= bus.I_OVF[k];
      end
    end
  end

endmodule

// File: tb/tb_enc_acq_ctrl.sv
// Bench for enc_acq_ctrl: directed scenarios with literal expectations plus
// randomized sessions, all checked every cycle against a behavioural model.
module tb_enc_acq_ctrl;

  localparam int NCH = 4;
  localparam int CW  = 64;
  localparam int PH_IDLE = 0, PH_RUN = 1, PH_DRAIN = 2, PH_DONE = 3;

  logic CLK;
  logic RST;

  enc_acq_ctrl_if #(.P_NCH(NCH), .P_CW(CW), .P_IW(2), .P_DROPW(16)) bus ();

  enc_acq_ctrl #(.P_NCH(NCH), .P_CW(CW), .P_IW(2), .P_DROPW(16)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  // Behavioural model state
  int        m_phase;
  bit [3:0]  m_mask, m_pend, m_hovf;
  bit [63:0] m_hold [NCH];
  bit        m_valid, m_ovf, m_tmo;
  bit [63:0] m_data;
  int        m_ch, m_drop, m_ptr;
  longint    m_tcnt;

  function automatic bit [3:0] e_arm();
    return (m_phase == PH_RUN) ? m_mask : 4'b0000;
  endfunction
  function automatic bit e_busy();
    return m_phase != PH_IDLE;
  endfunction
  function automatic bit e_done();
    return m_phase == PH_DONE;
  endfunction

  task automatic model_reset();
    m_phase = PH_IDLE; m_mask = 0; m_pend = 0; m_hovf = 0;
    m_valid = 0; m_ovf = 0; m_tmo = 0; m_data = 0;
    m_ch = 0; m_drop = 0; m_ptr = 0; m_tcnt = 0;
  endtask

  task automatic model_step();
    bit [3:0] rdy_en, pend_old;
    bit       valid_old, fire;
    int       g;
    if (RST) begin
      model_reset();
      return;
    end
    pend_old  = m_pend;
    valid_old = m_valid;
    rdy_en    = (m_phase == PH_RUN) ? (bus.I_RDY & m_mask) : 4'b0000;
    // Output slot: take the next pending channel in rotating order when free.
    if ((!m_valid || bus.I_ACK) && m_pend != 0) begin
      g = -1;
      for (int i = 0; i < NCH; i++) begin
        int k = (m_ptr + i) % NCH;
        if (g < 0 && m_pend[k]) g = k;
      end
      m_valid = 1; m_data = m_hold[g]; m_ch = g; m_ovf = m_hovf[g];
      m_pend[g] = 0;
      m_ptr = (g + 1) % NCH;
    end else if (bus.I_ACK) begin
      m_valid = 0;
    end
    for (int k = 0; k < NCH; k++) begin
      if (rdy_en[k]) begin
        if (m_pend[k]) m_drop = (m_drop < 65535) ? m_drop + 1 : 65535;
        m_hold[k] = bus.I_CNT[k*CW +: CW];
        m_hovf[k] = bus.I_OVF[k];
        m_pend[k] = 1;
      end
    end
    case (m_phase)
      PH_IDLE: if (bus.I_START) begin
        m_phase = PH_RUN; m_mask = bus.I_CH_EN;
        m_drop = 0; m_tmo = 0; m_tcnt = 0;
      end
      PH_RUN: begin
        fire = (bus.I_TIMEOUT != 0) && (m_tcnt == longint'(bus.I_TIMEOUT) - 1);
        if (bus.I_STOP) m_phase = PH_DRAIN;
        else if (fire) begin m_phase = PH_DRAIN; m_tmo = 1; end
        m_tcnt = (rdy_en != 0) ? 0 : m_tcnt + 1;
      end
      PH_DRAIN: if (pend_old == 0 && !valid_old) m_phase = PH_DONE;
      default:  m_phase = PH_IDLE;
    endcase
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge CLK);
      model_step();
    end
  end

  task automatic cmp(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Literal expectation applied to both the model and the DUT.
  task automatic lit(string nm, logic [63:0] dutv, logic [63:0] modv, logic [63:0] want);
    cmp({nm, "_model"}, modv, want);
    cmp({nm, "_dut"}, dutv, want);
  endtask

  task automatic look(string nm, bit v, int ch, logic [63:0] d);
    lit({nm, "_valid"}, 64'(bus.O_VALID), 64'(m_valid), 64'(v));
    lit({nm, "_ch"}, 64'(bus.O_CH), 64'(m_ch), 64'(ch));
    lit({nm, "_data"}, bus.O_DATA, m_data, d);
  endtask

  initial begin
    forever begin
      @(negedge CLK);
      if (cmp_en) begin
        cmp("arm", 64'(bus.O_ARM), 64'(e_arm()));
        cmp("busy", 64'(bus.O_BUSY), 64'(e_busy()));
        cmp("done", 64'(bus.O_DONE), 64'(e_done()));
        cmp("valid", 64'(bus.O_VALID), 64'(m_valid));
        cmp("timeout", 64'(bus.O_TIMEOUT), 64'(m_tmo));
        cmp("drop", 64'(bus.O_DROP), 64'(m_drop));
        if (m_valid) begin
          cmp("data", bus.O_DATA, m_data);
          cmp("ch", 64'(bus.O_CH), 64'(m_ch));
          cmp("ovf", 64'(bus.O_OVF), 64'(m_ovf));
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_cnt(int k, logic [63:0] v);
    bus.I_CNT[k*CW +: CW] = v;
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    while (e_busy() && n < budget) begin
      tick();
      n++;
    end
    if (e_busy()) begin
      total++;
      bad++;
      $display("FAIL wait_idle: still busy after %0d cycles", budget);
    end
  endtask

  task automatic check_all_zero(string nm);
    lit({nm, "_arm"}, 64'(bus.O_ARM), 64'(e_arm()), 0);
    lit({nm, "_valid"}, 64'(bus.O_VALID), 64'(m_valid), 0);
    lit({nm, "_data"}, bus.O_DATA, m_data, 0);
    lit({nm, "_ch"}, 64'(bus.O_CH), 64'(m_ch), 0);
    lit({nm, "_ovf"}, 64'(bus.O_OVF), 64'(m_ovf), 0);
    lit({nm, "_busy"}, 64'(bus.O_BUSY), 64'(e_busy()), 0);
    lit({nm, "_done"}, 64'(bus.O_DONE), 64'(e_done()), 0);
    lit({nm, "_tmo"}, 64'(bus.O_TIMEOUT), 64'(m_tmo), 0);
    lit({nm, "_drop"}, 64'(bus.O_DROP), 64'(m_drop), 0);
  endtask

  initial begin
    int len;
    RST = 1'b1;
    bus.I_START = 0; bus.I_STOP = 0; bus.I_CH_EN = 0; bus.I_TIMEOUT = 0;
    bus.I_CNT = '0; bus.I_OVF = 0; bus.I_RDY = 0; bus.I_ACK = 0;
    tick();
    cmp_en = 1'b1;
    tick();
    check_all_zero("reset");
    RST = 1'b0;

    // Two enabled channels captured together, drained back to back.
    bus.I_ACK = 1; bus.I_CH_EN = 4'b0101; bus.I_START = 1; tick(); bus.I_START = 0;
    lit("t1_arm", 64'(bus.O_ARM), 64'(e_arm()), 64'h5);
    bus.I_RDY = 4'b0101; set_cnt(0, 64'h10); set_cnt(2, 64'h30); tick(); bus.I_RDY = 0;
    lit("t1_lat", 64'(bus.O_VALID), 64'(m_valid), 0);
    tick(); look("t1_w0", 1, 0, 64'h10);
    tick(); look("t1_w1", 1, 2, 64'h30);
    tick(); lit("t1_end_valid", 64'(bus.O_VALID), 64'(m_valid), 0);
    lit("t1_drop", 64'(bus.O_DROP), 64'(m_drop), 0);

    // Ready on a masked-off channel.
    bus.I_RDY = 4'b0010; set_cnt(1, 64'h55); tick(); bus.I_RDY = 0;
    tick(); tick();
    lit("t2_valid", 64'(bus.O_VALID), 64'(m_valid), 0);
    lit("t2_drop", 64'(bus.O_DROP), 64'(m_drop), 0);
    bus.I_STOP = 1; tick(); bus.I_STOP = 0;
    wait_idle(20);

    // Overwrite of a pending snapshot while the output is stalled.
    bus.I_ACK = 0; bus.I_CH_EN = 4'b1000; bus.I_START = 1; tick(); bus.I_START = 0;
    bus.I_RDY = 4'b1000; set_cnt(3, 64'd5); tick(); bus.I_RDY = 0;
    tick(); look("t3_first", 1, 3, 64'd5);
    bus.I_RDY = 4'b1000; set_cnt(3, 64'd6); tick();
    set_cnt(3, 64'd7); tick(); bus.I_RDY = 0;
    tick(); look("t3_hold", 1, 3, 64'd5);
    lit("t3_drop", 64'(bus.O_DROP), 64'(m_drop), 1);
    tick(); tick(); look("t3_hold2", 1, 3, 64'd5);
    bus.I_ACK = 1; tick(); look("t3_second", 1, 3, 64'd7);
    tick(); lit("t3_end_valid", 64'(bus.O_VALID), 64'(m_valid), 0);
    lit("t3_end_drop", 64'(bus.O_DROP), 64'(m_drop), 1);
    bus.I_STOP = 1; tick(); bus.I_STOP = 0;
    wait_idle(20);

    // Idle timeout of 8 cycles.
    bus.I_TIMEOUT = 8; bus.I_CH_EN = 4'b1111; bus.I_START = 1; tick(); bus.I_START = 0;
    repeat (7) tick();
    lit("t4_run_busy", 64'(bus.O_BUSY), 64'(e_busy()), 1);
    lit("t4_run_arm", 64'(bus.O_ARM), 64'(e_arm()), 64'hf);
    lit("t4_run_tmo", 64'(bus.O_TIMEOUT), 64'(m_tmo), 0);
    tick();
    lit("t4_drain_arm", 64'(bus.O_ARM), 64'(e_arm()), 0);
    lit("t4_drain_tmo", 64'(bus.O_TIMEOUT), 64'(m_tmo), 1);
    lit("t4_drain_done", 64'(bus.O_DONE), 64'(e_done()), 0);
    tick(); lit("t4_done", 64'(bus.O_DONE), 64'(e_done()), 1);
    tick(); lit("t4_idle_busy", 64'(bus.O_BUSY), 64'(e_busy()), 0);
    lit("t4_idle_done", 64'(bus.O_DONE), 64'(e_done()), 0);
    bus.I_TIMEOUT = 0;

    // Stop with two words outstanding and a stalled consumer.
    bus.I_ACK = 0; bus.I_CH_EN = 4'b0011; bus.I_START = 1; tick(); bus.I_START = 0;
    lit("t5_tmo_clr", 64'(bus.O_TIMEOUT), 64'(m_tmo), 0);
    bus.I_RDY = 4'b0011; set_cnt(0, 64'hA0); set_cnt(1, 64'hA1); tick(); bus.I_RDY = 0;
    bus.I_STOP = 1; tick(); bus.I_STOP = 0;
    look("t5_w0", 1, 0, 64'hA0);
    for (int i = 0; i < 5; i++) begin
      tick();
      lit("t5_stall_busy", 64'(bus.O_BUSY), 64'(e_busy()), 1);
      lit("t5_stall_done", 64'(bus.O_DONE), 64'(e_done()), 0);
      look("t5_stall", 1, 0, 64'hA0);
    end
    bus.I_ACK = 1; tick(); look("t5_w1", 1, 1, 64'hA1);
    tick(); lit("t5_empty_valid", 64'(bus.O_VALID), 64'(m_valid), 0);
    lit("t5_empty_done", 64'(bus.O_DONE), 64'(e_done()), 0);
    tick(); lit("t5_done", 64'(bus.O_DONE), 64'(e_done()), 1);
    tick(); lit("t5_idle_busy", 64'(bus.O_BUSY), 64'(e_busy()), 0);
    lit("t5_idle_done", 64'(bus.O_DONE), 64'(e_done()), 0);

    // Reset in the middle of a run with output and a pending word.
    bus.I_ACK = 0; bus.I_CH_EN = 4'b0001; bus.I_START = 1; tick(); bus.I_START = 0;
    bus.I_RDY = 4'b0001; set_cnt(0, 64'h11); tick(); bus.I_RDY = 0;
    tick();
    bus.I_RDY = 4'b0001; set_cnt(0, 64'h22); tick(); bus.I_RDY = 0;
    look("t6_pre", 1, 0, 64'h11);
    RST = 1; tick(); RST = 0;
    check_all_zero("t6_rst");
    bus.I_ACK = 1; bus.I_START = 1; tick(); bus.I_START = 0;
    bus.I_RDY = 4'b0001; set_cnt(0, 64'h99); tick(); bus.I_RDY = 0;
    tick(); look("t6_after", 1, 0, 64'h99);
    lit("t6_drop", 64'(bus.O_DROP), 64'(m_drop), 0);
    bus.I_STOP = 1; tick(); bus.I_STOP = 0;
    wait_idle(20);

    // Randomized sessions.
    for (int s = 0; s < 40; s++) begin
      bus.I_TIMEOUT = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(1, 12));
      bus.I_CH_EN = 4'($urandom);
      bus.I_START = 1; tick(); bus.I_START = 0;
      len = $urandom_range(5, 60);
      for (int c = 0; c < len; c++) begin
        bus.I_RDY = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
        for (int k = 0; k < NCH; k++) set_cnt(k, {$urandom, $urandom});
        bus.I_OVF = 4'($urandom);
        bus.I_ACK = ($urandom_range(0, 3) != 0);
        bus.I_STOP = (c == len - 1) || ($urandom_range(0, 40) == 0);
        bus.I_START = ($urandom_range(0, 15) == 0);
        RST = ($urandom_range(0, 150) == 0);
        tick();
      end
      bus.I_RDY = 0; bus.I_STOP = 0; bus.I_START = 0; RST = 0;
      for (int n = 0; n < 300 && e_busy(); n++) begin
        bus.I_ACK = ($urandom_range(0, 1) == 1);
        bus.I_RDY = 4'($urandom);
        bus.I_STOP = ($urandom_range(0, 7) == 0);
        tick();
      end
      bus.I_STOP = 0; bus.I_RDY = 0;
      wait_idle(50);
      bus.I_ACK = 1;
      repeat (2) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
